// File: rtl/rv32i_defines_pkg.sv
// Shared RV32I encodings: opcodes, funct3 codes, canonical NOP and register names.
package rv32i_defines_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd1;
  localparam logic [4:0] REG_GP   = 5'd3;
  localparam logic [4:0] REG_S10  = 5'd26;
  localparam logic [4:0] REG_S11  = 5'd27;

endpackage

// File: rtl/rv32i_regs.sv
// 32 x 32 integer register file: two async read ports, one sync write port, x0 hardwired to zero.
module rv32i_regs
  import rv32i_defines_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1_c,
  output logic [31:0] rdata2_c,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [0:31];

  // Clear on reset, otherwise commit the write-back; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != REG_ZERO)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1_c = (raddr1 == REG_ZERO) ? 32'h0 : regs[raddr1];
  assign rdata2_c = (raddr2 == REG_ZERO) ? 32'h0 : regs[raddr2];

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: combinational decode/execute from inst_i, PC and rd updated at posedge.
module rv32i_core
  import rv32i_defines_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] inst_addr_o
);

  logic [XLEN-1:0] pc, pc_next, pc_plus4;
  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2, shamt;
  logic [2:0]      funct3;
  logic            alt;
  logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] rs1_val, rs2_val, alu_b, alu_res, wb_data;
  logic            br_taken, wb_en;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign alt    = inst_i[30];

  assign imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign imm_b = {{(XLEN-13){inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = XLEN'({inst_i[31:12], 12'h000});
  assign imm_j = {{(XLEN-21){inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  assign pc_plus4    = pc + XLEN'(4);
  assign inst_addr_o = pc;

  rv32i_regs u_regs (
    .clk      (clk),
    .rst      (rst),
    .raddr1   (rs1),
    .raddr2   (rs2),
    .rdata1_c (rs1_val),
    .rdata2_c (rs2_val),
    .we       (wb_en),
    .waddr    (rd),
    .wdata    (wb_data)
  );

  // ALU shared by OP and OP-IMM; inst[30] picks SUB (OP only) and SRA/SRAI.
  always_comb begin
    alu_b   = (opcode == OPC_OP) ? rs2_val : imm_i;
    shamt   = alu_b[4:0];
    alu_res = '0;
    case (funct3)
      F3_ADD:  alu_res = ((opcode == OPC_OP) && alt) ? rs1_val - alu_b : rs1_val + alu_b;
      F3_SLL:  alu_res = rs1_val << shamt;
      F3_SLT:  alu_res = XLEN'($signed(rs1_val) < $signed(alu_b));
      F3_SLTU: alu_res = XLEN'(rs1_val < alu_b);
      F3_XOR:  alu_res = rs1_val ^ alu_b;
      F3_SR:   alu_res = alt ? XLEN'($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
      F3_OR:   alu_res = rs1_val | alu_b;
      F3_AND:  alu_res = rs1_val & alu_b;
      default: alu_res = '0;
    endcase
  end

  // Branch condition; reserved funct3 encodings fall through as not taken.
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      F3_BEQ:  br_taken = (rs1_val == rs2_val);
      F3_BNE:  br_taken = (rs1_val != rs2_val);
      F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: br_taken = (rs1_val <  rs2_val);
      F3_BGEU: br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Write-back and next-PC selection; memory, fence, system and unknown opcodes retire as NOPs.
  always_comb begin
    wb_en   = 1'b0;
    wb_data = '0;
    pc_next = pc_plus4;
    case (opcode)
      OPC_OP_IMM, OPC_OP: begin
        wb_en   = 1'b1;
        wb_data = alu_res;
      end
      OPC_LUI: begin
        wb_en   = 1'b1;
        wb_data = imm_u;
      end
      OPC_AUIPC: begin
        wb_en   = 1'b1;
        wb_data = pc + imm_u;
      end
      OPC_JAL: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        pc_next = pc + imm_j;
      end
      OPC_JALR: begin
        wb_en   = 1'b1;
        wb_data = pc_plus4;
        pc_next = (rs1_val + imm_i) & ~XLEN'(1);
      end
      OPC_BRANCH: begin
        if (br_taken) pc_next = pc + imm_b;
      end
      OPC_LOAD, OPC_STORE, OPC_FENCE, OPC_SYSTEM: begin
        wb_en = 1'b0;
      end
      default: begin
        wb_en = 1'b0;
      end
    endcase
  end

  // Program counter; reset wins over any jump or branch in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

endmodule

// File: tb/tb_rv32i_core.sv
// Bench for rv32i_core: directed program with known results, then random programs against an ISS.
module tb_rv32i_core;
  import rv32i_defines_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic [31:0] rom_mem [0:4095];
  logic [31:0] m_regs  [0:31];
  logic [31:0] m_pc;
  logic [31:0] pc_trace [$];
  int          n_checks = 0;
  int          n_errors = 0;

  rv32i_core #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_i      (inst),
    .inst_addr_o (inst_addr)
  );

  assign inst = rom_mem[inst_addr[13:2]];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, OPC_JAL};
  endfunction

  // Reference arithmetic; alt means subtract for funct3 0 and arithmetic right shift for funct3 5.
  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b, input logic alt);
    int unsigned sh;
    sh = int'(b % 32);
    case (f3)
      3'd0: return alt ? a + (~b + 32'd1) : a + b;
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return (alt && a[31]) ? ((a >> sh) | ~(32'hFFFF_FFFF >> sh)) : (a >> sh);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Instruction-set model: retire the word at m_pc.
  task automatic model_exec();
    logic [31:0] ins, a, b, res, nxt;
    logic        wr;
    ins = rom_mem[m_pc[13:2]];
    a   = m_regs[ins[19:15]];
    b   = m_regs[ins[24:20]];
    nxt = m_pc + 32'd4;
    wr  = 1'b0;
    res = 32'h0;
    case (ins[6:0])
      7'h37: begin wr = 1'b1; res = {ins[31:12], 12'h000}; end
      7'h17: begin wr = 1'b1; res = m_pc + {ins[31:12], 12'h000}; end
      7'h6F: begin
        wr = 1'b1; res = m_pc + 32'd4;
        nxt = m_pc + 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'h67: begin
        wr = 1'b1; res = m_pc + 32'd4;
        nxt = (a + 32'($signed(ins[31:20]))) & 32'hFFFF_FFFE;
      end
      7'h63: if (br_ref(ins[14:12], a, b))
               nxt = m_pc + 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      7'h13: begin
        wr = 1'b1;
        res = alu_ref(ins[14:12], a, 32'($signed(ins[31:20])), ins[30] && (ins[14:12] == 3'd5));
      end
      7'h33: begin wr = 1'b1; res = alu_ref(ins[14:12], a, b, ins[30]); end
      default: ;
    endcase
    if (wr && (ins[11:7] != 5'd0)) m_regs[ins[11:7]] = res;
    m_pc = nxt;
  endtask

  // One clock in lockstep with the model, then compare the PC.
  task automatic step(input logic r);
    rst = r;
    if (r) begin
      m_pc = 32'h0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else begin
      model_exec();
    end
    @(posedge clk);
    @(negedge clk);
    check(r ? "pc_rst" : "pc", inst_addr, m_pc);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 1; i < 32; i++)
      check($sformatf("%s x%0d", tag, i), dut.u_regs.regs[i], m_regs[i]);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] raw;
    logic [6:0]  opc;
    int unsigned k;
    rd  = 5'($urandom_range(0, 11));
    rs1 = 5'($urandom_range(0, 11));
    rs2 = 5'($urandom_range(0, 11));
    f3  = 3'($urandom_range(0, 7));
    imm = 12'($urandom);
    raw = $urandom;
    k   = $urandom_range(0, 99);
    if (k < 30) begin
      if (f3 == F3_SLL)     imm = {7'h00, imm[4:0]};
      else if (f3 == F3_SR) imm = {1'b0, imm[10], 5'h00, imm[4:0]};
      return enc_i(OPC_OP_IMM, rd, f3, rs1, imm);
    end
    if (k < 55) return enc_r(((f3 == F3_ADD) || (f3 == F3_SR)) && raw[0] ? 7'h20 : 7'h00,
                             rs2, rs1, f3, rd);
    if (k < 62) return enc_u(OPC_LUI, rd, raw[31:12]);
    if (k < 67) return enc_u(OPC_AUIPC, rd, raw[31:12]);
    if (k < 77) begin
      f3 = raw[2] ? {1'b1, raw[1:0]} : {2'b00, raw[0]};
      return enc_b(f3, rs1, rs2, {raw[15:4], 1'b0});
    end
    if (k < 82) return enc_j(rd, {raw[23:4], 1'b0});
    if (k < 87) return enc_i(OPC_JALR, rd, 3'd0, rs1, imm);
    case (raw[2:0])
      3'd0:    opc = OPC_LOAD;
      3'd1:    opc = OPC_STORE;
      3'd2:    opc = OPC_FENCE;
      3'd3:    opc = OPC_SYSTEM;
      default: opc = 7'h0B;
    endcase
    return {raw[31:7], opc};
  endfunction

  initial begin
    int cyc;

    // Directed program exercising the documented corner cases.
    for (int i = 0; i < 4096; i++) rom_mem[i] = INST_NOP;
    rom_mem[0]  = enc_i(OPC_OP_IMM, 5'd10, F3_ADD, 5'd0, 12'd2);
    rom_mem[1]  = enc_i(OPC_OP_IMM, 5'd11, F3_ADD, 5'd11, 12'd1);
    rom_mem[2]  = enc_r(7'h00, 5'd10, 5'd11, F3_ADD, 5'd12);
    rom_mem[3]  = enc_r(7'h20, 5'd10, 5'd12, F3_ADD, 5'd13);
    rom_mem[4]  = enc_u(OPC_AUIPC, 5'd14, 20'h00001);
    rom_mem[5]  = enc_b(F3_BNE, 5'd0, 5'd0, 13'd8);
    rom_mem[6]  = enc_b(F3_BEQ, 5'd0, 5'd0, 13'd8);
    rom_mem[7]  = enc_i(OPC_OP_IMM, 5'd15, F3_ADD, 5'd0, 12'd99);
    rom_mem[8]  = enc_j(REG_RA, 21'd12);
    rom_mem[9]  = enc_j(5'd0, 21'h20);
    rom_mem[11] = enc_u(OPC_LUI, 5'd5, 20'h12345);
    rom_mem[12] = enc_i(OPC_OP_IMM, 5'd6, F3_ADD, 5'd0, 12'hFFF);
    rom_mem[13] = enc_i(OPC_OP_IMM, 5'd7, F3_ADD, 5'd0, 12'd1);
    rom_mem[14] = enc_r(7'h00, 5'd7, 5'd6, F3_SLT, 5'd8);
    rom_mem[15] = enc_r(7'h00, 5'd7, 5'd6, F3_SLTU, 5'd9);
    rom_mem[16] = enc_i(OPC_JALR, 5'd0, 3'd0, REG_RA, 12'd0);
    rom_mem[17] = enc_u(OPC_LUI, 5'd16, 20'h80000);
    rom_mem[18] = enc_i(OPC_OP_IMM, 5'd17, F3_SR, 5'd16, 12'h404);
    rom_mem[19] = enc_i(OPC_OP_IMM, 5'd0, F3_ADD, 5'd0, 12'd5);
    rom_mem[20] = 32'h0000_2903;
    rom_mem[21] = 32'h0000_0073;
    rom_mem[22] = enc_r(7'h00, 5'd0, 5'd0, F3_ADD, 5'd19);
    rom_mem[23] = enc_i(OPC_OP_IMM, REG_S10, F3_ADD, 5'd0, 12'd1);
    rom_mem[24] = enc_i(OPC_OP_IMM, REG_S11, F3_ADD, 5'd0, 12'd1);
    rom_mem[25] = enc_j(5'd0, 21'd0);

    for (int i = 0; i < 10; i++) step(1'b1);
    check("reset pc", inst_addr, 32'h0);
    for (int i = 1; i < 32; i++) check($sformatf("reset x%0d", i), dut.u_regs.regs[i], 32'h0);

    pc_trace.push_back(inst_addr);
    cyc = 0;
    while ((dut.u_regs.regs[REG_S10] !== 32'd1) && (cyc < 100)) begin
      step(1'b0);
      pc_trace.push_back(inst_addr);
      cyc++;
    end
    check("x26 done", dut.u_regs.regs[REG_S10], 32'd1);
    cyc = 0;
    while ((dut.u_regs.regs[REG_S11] !== 32'd1) && (cyc < 20)) begin
      step(1'b0);
      cyc++;
    end
    check("x27 pass", dut.u_regs.regs[REG_S11], 32'd1);
    check("x3 testnum", dut.u_regs.regs[REG_GP], 32'd0);

    check("trace0", pc_trace[0], 32'h00);
    check("trace1", pc_trace[1], 32'h04);
    check("trace2", pc_trace[2], 32'h08);
    check("bne not taken", pc_trace[6], 32'h18);
    check("beq taken", pc_trace[7], 32'h20);
    check("jal target", pc_trace[8], 32'h2C);
    check("jalr target", pc_trace[14], 32'h24);
    check("addi x10", dut.u_regs.regs[10], 32'd2);
    check("addi x11", dut.u_regs.regs[11], 32'd1);
    check("add x12", dut.u_regs.regs[12], 32'd3);
    check("sub x13", dut.u_regs.regs[13], 32'd1);
    check("auipc x14", dut.u_regs.regs[14], 32'h0000_1010);
    check("skipped x15", dut.u_regs.regs[15], 32'h0);
    check("jal link x1", dut.u_regs.regs[1], 32'h24);
    check("lui x5", dut.u_regs.regs[5], 32'h1234_5000);
    check("slt x8", dut.u_regs.regs[8], 32'd1);
    check("sltu x9", dut.u_regs.regs[9], 32'd0);
    check("srai x17", dut.u_regs.regs[17], 32'hF800_0000);
    check("load nop x18", dut.u_regs.regs[18], 32'h0);
    check("x0 read x19", dut.u_regs.regs[19], 32'h0);
    check_regs("dir");

    // Random programs over the whole ROM, with occasional mid-program resets.
    for (int i = 0; i < 4096; i++) rom_mem[i] = rand_inst();
    step(1'b1);
    step(1'b1);
    check_regs("rnd reset");
    for (int k = 0; k < 3000; k++) begin
      step((k == 1500) || ($urandom_range(0, 399) == 0));
      if ((k % 64) == 63) check_regs("rnd");
      if (n_errors > 20) break;
    end
    check_regs("rnd end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
